// File: rtl/rs15_syndrome_calc.sv
// RS(15,11) receiver syndrome calculator over GF(2^4), poly x^4+x+1.
// Accumulates S_j = r(alpha^j), j = 1..NSYN, by Horner's rule, one symbol per accepted beat.
module rs15_syndrome_calc #(
  parameter int unsigned N    = 15,
  parameter int unsigned NSYN = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_symbol,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] syn1,
  output logic [3:0] syn2,
  output logic [3:0] syn3,
  output logic [3:0] syn4,
  output logic       err_flag
);

  localparam logic [3:0] CntLast = 4'(N - 1);

  // Multiply by alpha: shift left, fold x^4 back as x+1.
  function automatic logic [3:0] mul_alpha(input logic [3:0] a);
    return {a[2], a[1], a[0] ^ a[3], a[3]};
  endfunction

  // Multiply by alpha^pw; loop bound is constant so this unrolls to an XOR network.
  function automatic logic [3:0] mul_alpha_pow(input logic [3:0] a, input int unsigned pw);
    logic [3:0] r;
    r = a;
    for (int unsigned k = 0; k < NSYN; k++) begin
      if (k < pw) r = mul_alpha(r);
    end
    return r;
  endfunction

  logic [3:0] cnt_q;
  logic [3:0] acc_q [NSYN];
  logic [3:0] acc_d [NSYN];
  logic [3:0] syn_q [NSYN];
  logic       out_valid_q;
  logic       err_flag_q;
  logic       err_d;
  logic       accept;
  logic       last;

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CntLast);

  always_comb begin
    err_d = 1'b0;
    for (int unsigned j = 0; j < NSYN; j++) begin
      acc_d[j] = mul_alpha_pow(acc_q[j], j + 1) ^ in_symbol;
      err_d    = err_d | (|acc_d[j]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      for (int unsigned j = 0; j < NSYN; j++) begin
        acc_q[j] <= '0;
        syn_q[j] <= '0;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (last) begin
          // Final Horner step lands straight in the result registers.
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          err_flag_q  <= err_d;
          for (int unsigned j = 0; j < NSYN; j++) begin
            syn_q[j] <= acc_d[j];
            acc_q[j] <= '0;
          end
        end else begin
          cnt_q <= cnt_q + 4'd1;
          for (int unsigned j = 0; j < NSYN; j++) begin
            acc_q[j] <= acc_d[j];
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign err_flag  = err_flag_q;
  assign syn1      = syn_q[0];
  assign syn2      = syn_q[1];
  assign syn3      = syn_q[2];
  assign syn4      = syn_q[3];

endmodule

// File: tb/tb_rs15_syndrome_calc.sv
// Scoreboard bench for rs15_syndrome_calc: expected syndromes queued at issue time,
// popped by a monitor on every output handshake.
module tb_rs15_syndrome_calc;

  typedef logic [3:0] cw_t [15];

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_symbol = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] syn1, syn2, syn3, syn4;
  logic       err_flag;

  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  bit          rand_ready = 1'b0;
  logic [16:0] exp_q [$];
  logic [16:0] mon_exp;

  rs15_syndrome_calc dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_symbol (in_symbol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .syn1      (syn1),
    .syn2      (syn2),
    .syn3      (syn3),
    .syn4      (syn4),
    .err_flag  (err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: plain polynomial evaluation in GF(16).
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'({4'h0, a}) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] alpha_pow(input int k);
    logic [3:0] r;
    r = 4'h1;
    repeat (k % 15) r = gf_mul(r, 4'h2);
    return r;
  endfunction

  // cw[0] is sent first and is the coefficient of x^14.
  function automatic logic [16:0] model(input cw_t cw);
    logic [3:0] s [4];
    for (int j = 1; j <= 4; j++) begin
      s[j-1] = 4'h0;
      for (int idx = 0; idx < 15; idx++) begin
        s[j-1] = s[j-1] ^ gf_mul(cw[idx], alpha_pow(j * (14 - idx)));
      end
    end
    return {s[0], s[1], s[2], s[3], |{s[0], s[1], s[2], s[3]}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && in_valid && in_ready) accepted++;
      if (!sys_rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h required none",
                   {syn1, syn2, syn3, syn4, err_flag});
        end else begin
          mon_exp = exp_q.pop_front();
          check("syndromes", 32'({syn1, syn2, syn3, syn4, err_flag}), 32'(mon_exp));
        end
      end
    end
  endtask

  task automatic send_sym(input logic [3:0] s, input int max_gap);
    int  gap;
    int  budget;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid  = 1'b1;
    in_symbol = s;
    budget    = 0;
    do begin
      @(negedge sys_clk);
      ok = in_ready;
      tick();
      budget++;
    end while (!ok && budget < 300);
    if (!ok) check("accept_timeout", 32'(ok), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_cw(input cw_t cw, input int max_gap, input bit push,
                         input logic [16:0] expv);
    if (push) exp_q.push_back(expv);
    for (int idx = 0; idx < 15; idx++) send_sym(cw[idx], max_gap);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'({in_ready, out_valid, syn1, syn2, syn3, syn4, err_flag}),
          32'({1'b1, 1'b0, 16'h0000, 1'b0}));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    cw_t zero_cw, cw;
    int  base;

    for (int i = 0; i < 15; i++) zero_cw[i] = 4'h0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_state("reset_state");
    tick();

    // Directed vectors.
    send_cw(zero_cw, 0, 1'b1, {4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
    @(negedge sys_clk);
    check("latency_valid", 32'(out_valid), 32'(1));
    tick();
    cw = zero_cw; cw[14] = 4'h1;
    send_cw(cw, 0, 1'b1, {4'h1, 4'h1, 4'h1, 4'h1, 1'b1});
    cw = zero_cw; cw[13] = 4'h1;
    send_cw(cw, 0, 1'b1, {4'h2, 4'h4, 4'h8, 4'h3, 1'b1});
    cw = zero_cw; cw[0] = 4'h1;
    send_cw(cw, 0, 1'b1, {4'h9, 4'hD, 4'hF, 4'hE, 1'b1});
    drain();

    // Backpressure: A pending stalls B until out_ready rises.
    base = accepted;
    out_ready = 1'b0;
    cw = zero_cw; cw[14] = 4'h1;
    send_cw(cw, 0, 1'b1, {4'h1, 4'h1, 4'h1, 4'h1, 1'b1});
    fork
      send_cw(zero_cw, 0, 1'b1, {4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
      begin
        repeat (6) @(negedge sys_clk);
        check("bp_in_ready_low", 32'(in_ready), 32'(0));
        check("bp_hold", 32'({out_valid, syn1, syn2, syn3, syn4, err_flag}),
              32'({1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 1'b1}));
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_accepted", 32'(accepted - base), 32'(30));

    // Idle gaps mid-codeword.
    cw = zero_cw; cw[13] = 4'h1;
    send_cw(cw, 3, 1'b1, {4'h2, 4'h4, 4'h8, 4'h3, 1'b1});
    drain();

    // Reset drops a pending result and discards a partial codeword.
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) cw[i] = 4'($urandom_range(0, 15));
    send_cw(cw, 0, 1'b0, 17'h0);
    sys_rst = 1'b1;
    tick();
    @(negedge sys_clk);
    check_reset_state("reset_drop_pending");
    sys_rst   = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_sym(4'($urandom_range(1, 15)), 0);
    sys_rst = 1'b1;
    tick();
    @(negedge sys_clk);
    check_reset_state("reset_mid_codeword");
    sys_rst = 1'b0;
    tick();
    send_cw(zero_cw, 0, 1'b1, {4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
    drain();

    // Random codewords, random gaps and random out_ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 15; i++) cw[i] = 4'($urandom_range(0, 15));
      if (n % 4 == 0) begin
        for (int i = 0; i < 15; i++) cw[i] = 4'h0;
        cw[$urandom_range(0, 14)] = 4'($urandom_range(1, 15));
      end
      send_cw(cw, 2, 1'b1, model(cw));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
